// File: rtl/hsca_arith_pkg.sv
// Shared arithmetic definitions for the sequential multiplier and its bench.
//   MUL_WIDTH   : operand width supported by the cla16x16 datapath.
//   MUL_STEPS   : number of shift-add steps (one per multiplier bit).
//   MUL_CNT_W   : step-counter width, wide enough to hold 0..MUL_STEPS.
//   mul_state_e : FSM encoding. IDLE=0, RUN=1, DONE=2; code 3 is illegal.
package hsca_arith_pkg;

  localparam int MUL_WIDTH = 16;
  localparam int MUL_STEPS = 16;
  localparam int MUL_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/cla16x16.sv
// 16-bit two-level carry-lookahead adder.
// Four 4-bit groups produce group generate/propagate; a second lookahead
// level forms the group carries, which then ripple-free feed each bit.
// Ports:
//   a, b : 16-bit addends
//   cin  : carry in
//   s    : 17-bit sum, s[16] is the carry out
module cla16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [16:0] s
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;
  logic [15:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end
  end

  // Second-level lookahead: every group carry is a flat function of cin.
  always_comb begin
    grp_c[0] = cin;
    grp_c[1] = grp_g[0] | (grp_p[0] & cin);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
    grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = grp_c[k];
      c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & grp_c[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
    end
  end

  assign s = {grp_c[4], p ^ c};

endmodule

// File: rtl/seq_mul16_ctrl.sv
// Sequential 16x16 unsigned shift-add multiplier with valid/ready handshakes.
// One cla16x16 is reused for 16 RUN cycles; hi:lo is a combined accumulator /
// multiplier shift register, so out_p = {hi, lo} is the product in DONE.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : operand handshake; in_ready is high only in IDLE
//   in_a, in_b          : multiplicand, multiplier (sampled at accept only)
//   out_valid/out_ready : result handshake; out_valid is high only in DONE
//   out_p               : 32-bit product, register contents {hi, lo}
//   busy                : state != IDLE
// Configuration macro MUL_ZERO_BYPASS_EN: when defined, a zero operand skips
// RUN and goes straight to DONE with a zero product.
module seq_mul16_ctrl
  import hsca_arith_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  if (WIDTH != MUL_WIDTH) begin : g_bad_width
    $error("seq_mul16_ctrl: WIDTH must be 16 to match cla16x16");
  end

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   sum;

  // Partial product for this step: the multiplier bit currently at lo[0].
  assign add_b = lo_q[0] ? mcand_q : '0;

  cla16x16 u_cla (
    .a   (hi_q),
    .b   (add_b),
    .cin (1'b0),
    .s   (sum)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d = in_a;
          hi_d    = '0;
          lo_d    = in_b;
          cnt_d   = '0;
          state_d = ST_RUN;
`ifdef MUL_ZERO_BYPASS_EN
          if ((in_a == '0) || (in_b == '0)) begin
            lo_d    = '0;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_RUN: begin
        // Shift the 33-bit {carry, sum, lo} right by one: the adder carry
        // lands in hi[15] and the sum LSB becomes a finished product bit.
        hi_d  = sum[WIDTH:1];
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_STEPS - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_p = {hi_q, lo_q};
  assign busy  = (state_q != ST_IDLE);

endmodule
